// File: rtl/btn_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : btn_conditioner
// Purpose  : Per-channel button synchronizer, debouncer, edge/long-press/
//            auto-repeat pulse generator and toggle latch.
// Revision : 1.0 - initial release
// ============================================================================
module btn_conditioner #(
    parameter int N_BTN         = 2,
    parameter int DEB_CYCLES    = 1000000,
    parameter int LONG_CYCLES   = 100000000,
    parameter int REPEAT_CYCLES = 20000000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [N_BTN-1:0] btn_in,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic [N_BTN-1:0] btn_long,
    output logic [N_BTN-1:0] btn_repeat,
    output logic [N_BTN-1:0] btn_toggle
);

    localparam int c_DEB_W  = $clog2(DEB_CYCLES + 1);
    localparam int c_HOLD_W = $clog2(LONG_CYCLES + 1);
    localparam int c_REP_W  = (REPEAT_CYCLES > 0) ? $clog2(REPEAT_CYCLES + 1) : 1;

    localparam logic [c_DEB_W-1:0]  c_DEB_LAST = c_DEB_W'(DEB_CYCLES - 1);
    localparam logic [c_HOLD_W-1:0] c_LONG     = c_HOLD_W'(LONG_CYCLES);
    localparam logic [c_REP_W-1:0]  c_REP_LAST = c_REP_W'((REPEAT_CYCLES > 0) ? REPEAT_CYCLES - 1 : 0);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_HELD   = 2'd1;
    localparam logic [1:0] c_REPEAT = 2'd2;

    logic             r_armed;
    logic [N_BTN-1:0] r_sync_meta;
    logic [N_BTN-1:0] r_sync;

    // The first edge after reset release is not used for sampling, so a
    // button held through reset is seen as a fresh press one cycle later.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_armed     <= 1'b0;
            r_sync_meta <= '0;
            r_sync      <= '0;
        end else begin
            r_armed <= 1'b1;
            if (r_armed) begin
                r_sync_meta <= btn_in;
                r_sync      <= r_sync_meta;
            end
        end
    end

    generate
        for (genvar i = 0; i < N_BTN; i++) begin : g_ch
            logic [c_DEB_W-1:0]  r_deb_cnt;
            logic                r_level;
            logic                r_press;
            logic                r_release;
            logic                r_toggle;
            logic                w_diff;
            logic                w_deb_done;
            logic                w_rise;
            logic                w_fall;

            logic [1:0]          r_state;
            logic [1:0]          w_state_nxt;
            logic [c_HOLD_W-1:0] r_hold_cnt;
            logic [c_HOLD_W-1:0] w_hold_nxt;
            logic [c_REP_W-1:0]  r_rep_cnt;
            logic [c_REP_W-1:0]  w_rep_cnt_nxt;
            logic                r_long;
            logic                r_repeat;
            logic                w_long_nxt;
            logic                w_repeat_nxt;

            assign w_diff     = r_sync[i] ^ r_level;
            assign w_deb_done = w_diff && (r_deb_cnt == c_DEB_LAST);
            assign w_rise     = w_deb_done && r_sync[i];
            assign w_fall     = w_deb_done && !r_sync[i];

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_deb_cnt <= '0;
                    r_level   <= 1'b0;
                    r_press   <= 1'b0;
                    r_release <= 1'b0;
                    r_toggle  <= 1'b0;
                end else begin
                    if (!w_diff || w_deb_done) begin
                        r_deb_cnt <= '0;
                    end else begin
                        r_deb_cnt <= r_deb_cnt + 1'b1;
                    end
                    if (w_deb_done) begin
                        r_level <= r_sync[i];
                    end
                    r_press   <= w_rise;
                    r_release <= w_fall;
                    if (w_rise) begin
                        r_toggle <= ~r_toggle;
                    end
                end
            end

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_state    <= c_IDLE;
                    r_hold_cnt <= '0;
                    r_rep_cnt  <= '0;
                    r_long     <= 1'b0;
                    r_repeat   <= 1'b0;
                end else begin
                    r_state    <= w_state_nxt;
                    r_hold_cnt <= w_hold_nxt;
                    r_rep_cnt  <= w_rep_cnt_nxt;
                    r_long     <= w_long_nxt;
                    r_repeat   <= w_repeat_nxt;
                end
            end

            always_comb begin
                w_state_nxt = r_state;
                case (r_state)
                    c_IDLE:   if (w_rise) w_state_nxt = c_HELD;
                    c_HELD: begin
                        if (w_fall)                    w_state_nxt = c_IDLE;
                        else if (r_hold_cnt == c_LONG) w_state_nxt = c_REPEAT;
                    end
                    c_REPEAT: if (w_fall) w_state_nxt = c_IDLE;
                    default:  w_state_nxt = c_IDLE;
                endcase
            end

            // Release takes priority so no long/repeat pulse coincides with it.
            always_comb begin
                w_hold_nxt    = r_hold_cnt;
                w_rep_cnt_nxt = r_rep_cnt;
                w_long_nxt    = 1'b0;
                w_repeat_nxt  = 1'b0;
                case (r_state)
                    c_IDLE: begin
                        w_hold_nxt    = w_rise ? c_HOLD_W'(1) : '0;
                        w_rep_cnt_nxt = '0;
                    end
                    c_HELD: begin
                        if (w_fall) begin
                            w_hold_nxt = '0;
                        end else if (r_hold_cnt == c_LONG) begin
                            w_long_nxt    = 1'b1;
                            w_rep_cnt_nxt = '0;
                        end else begin
                            w_hold_nxt = r_hold_cnt + 1'b1;
                        end
                    end
                    c_REPEAT: begin
                        if (w_fall) begin
                            w_hold_nxt    = '0;
                            w_rep_cnt_nxt = '0;
                        end else if (REPEAT_CYCLES > 0) begin
                            if (r_rep_cnt == c_REP_LAST) begin
                                w_repeat_nxt  = 1'b1;
                                w_rep_cnt_nxt = '0;
                            end else begin
                                w_rep_cnt_nxt = r_rep_cnt + 1'b1;
                            end
                        end
                    end
                    default: begin
                        w_hold_nxt    = '0;
                        w_rep_cnt_nxt = '0;
                    end
                endcase
            end

            assign btn_level[i]   = r_level;
            assign btn_press[i]   = r_press;
            assign btn_release[i] = r_release;
            assign btn_long[i]    = r_long;
            assign btn_repeat[i]  = r_repeat;
            assign btn_toggle[i]  = r_toggle;
        end
    endgenerate

endmodule
`default_nettype wire
